// File: rtl/rms_meter_if.sv
// Handshake and result bus for rms_meter: control strobes in, window results out.
interface rms_meter_if #(parameter int DATA_W = 12);
  logic                  start;
  logic                  stop;
  logic                  mode_cont;
  logic [DATA_W-1:0]     ad_data;
  logic                  busy;
  logic                  done;
  logic [2*DATA_W-1:0]   ms_out;
  logic [DATA_W-1:0]     rms_out;

  modport master (output start, stop, mode_cont, ad_data,
                  input  busy, done, ms_out, rms_out);
  modport slave  (input  start, stop, mode_cont, ad_data,
                  output busy, done, ms_out, rms_out);
endinterface

// File: rtl/rms_meter.sv
// Windowed mean-square / RMS meter over 2^LOG2_N ADC samples taken on samp_clk edges.
// Define RMS_SQRT_EN to build the restoring square-root stage; otherwise rms_out is 0.
module rms_meter #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 8,
  parameter int SIGNED = 0
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        samp_clk,
  rms_meter_if.slave  bus
);
  localparam int SQ_W  = 2*DATA_W;
  localparam int ACC_W = SQ_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] N_SAMP = CNT_W'(1 << LOG2_N);

  typedef enum logic [2:0] {IDLE, ACCUM, LATCH, SQRT, DONE} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  samp_q, samp_d;
  logic [SQ_W-1:0]    sq_q, sq_d;
  logic [1:0]         vld_pipe_q, vld_pipe_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [SQ_W-1:0]    ms_hold_q, ms_hold_d;
  logic [SQ_W-1:0]    ms_out_q, ms_out_d;
  logic               strobe;
  logic [DATA_W-1:0]  mag;
  logic [SQ_W-1:0]    mag_ext;

`ifdef RMS_SQRT_EN
  localparam int SC_W = $clog2(DATA_W);
  logic [SQ_W-1:0]    op_q, op_d;
  logic [DATA_W+1:0]  rem_q, rem_d, rem_t, trial;
  logic [DATA_W-1:0]  root_q, root_d;
  logic [SC_W-1:0]    scnt_q, scnt_d;
  logic [DATA_W-1:0]  rms_out_q, rms_out_d;
`endif

  assign strobe  = sync2_q & ~dly_q;
  // Signed squares go through the magnitude so the full-scale negative code fits DATA_W bits.
  assign mag     = (SIGNED != 0 && samp_q[DATA_W-1]) ? -samp_q : samp_q;
  assign mag_ext = {{DATA_W{1'b0}}, mag};

  always_comb begin
    state_d    = state_q;
    sync1_d    = samp_clk;
    sync2_d    = sync1_q;
    dly_d      = sync2_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    samp_d     = samp_q;
    sq_d       = mag_ext * mag_ext;
    vld_pipe_d = {vld_pipe_q[0], 1'b0};
    acc_d      = vld_pipe_q[1] ? acc_q + {{LOG2_N{1'b0}}, sq_q} : acc_q;
    ms_hold_d  = ms_hold_q;
    ms_out_d   = ms_out_q;
`ifdef RMS_SQRT_EN
    op_d      = op_q;
    rem_d     = rem_q;
    root_d    = root_q;
    scnt_d    = scnt_q;
    rms_out_d = rms_out_q;
    rem_t     = {rem_q[DATA_W-1:0], op_q[SQ_W-1 -: 2]};
    trial     = {root_q, 2'b01};
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        acc_d   = '0;
        cnt_d   = '0;
        mode_d  = bus.mode_cont;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (strobe && cnt_q != N_SAMP) begin
          samp_d        = bus.ad_data;
          vld_pipe_d[0] = 1'b1;
          cnt_d         = cnt_q + CNT_W'(1);
        end else if (cnt_q == N_SAMP && vld_pipe_q == 2'b00) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        ms_hold_d = acc_q[ACC_W-1 -: SQ_W];
`ifdef RMS_SQRT_EN
        op_d    = acc_q[ACC_W-1 -: SQ_W];
        rem_d   = '0;
        root_d  = '0;
        scnt_d  = SC_W'(DATA_W-1);
        state_d = SQRT;
`else
        state_d = DONE;
`endif
      end
`ifdef RMS_SQRT_EN
      SQRT: begin
        op_d = op_q << 2;
        if (rem_t >= trial) begin
          rem_d  = rem_t - trial;
          root_d = {root_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d  = rem_t;
          root_d = {root_q[DATA_W-2:0], 1'b0};
        end
        scnt_d = scnt_q - SC_W'(1);
        if (scnt_q == '0) state_d = DONE;
      end
`endif
      DONE: begin
        if (mode_q) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.stop) state_d = IDLE;
    // Results load on entry to DONE so they are valid alongside the done pulse.
    if (state_d == DONE) begin
      ms_out_d = ms_hold_d;
`ifdef RMS_SQRT_EN
      rms_out_d = root_d;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dly_q      <= 1'b0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      samp_q     <= '0;
      sq_q       <= '0;
      vld_pipe_q <= '0;
      acc_q      <= '0;
      ms_hold_q  <= '0;
      ms_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      dly_q      <= dly_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      sq_q       <= sq_d;
      vld_pipe_q <= vld_pipe_d;
      acc_q      <= acc_d;
      ms_hold_q  <= ms_hold_d;
      ms_out_q   <= ms_out_d;
    end
  end

`ifdef RMS_SQRT_EN
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      op_q      <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      scnt_q    <= '0;
      rms_out_q <= '0;
    end else begin
      op_q      <= op_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      scnt_q    <= scnt_d;
      rms_out_q <= rms_out_d;
    end
  end
  assign bus.rms_out = rms_out_q;
`else
  assign bus.rms_out = '0;
`endif

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.ms_out = ms_out_q;
endmodule

// File: doc/rms_meter.md
RMS_METER -- requirements
Module: rms_meter

Interface
REQ-001 SHALL have parameter DATA_W, default 12: ADC sample width in bits, 4..16.
REQ-002 SHALL have parameter LOG2_N, default 8: the window length is N = 2^LOG2_N samples, 1..16.
REQ-003 SHALL have parameter SIGNED, default 0: 0 means ad_data is unsigned; 1 means ad_data is two's complement.
REQ-004 SHALL have port clk_sys, input, 1 bit: the single system clock. All logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port samp_clk, input, 1 bit: slow sampling clock, asynchronous to clk_sys.
REQ-007 SHALL have port start, input, 1 bit: 1-cycle request to begin measurement.
REQ-008 SHALL have port stop, input, 1 bit: 1-cycle request to abort measurement.
REQ-009 SHALL have port mode_cont, input, 1 bit: 1 selects continuous windows; 0 selects single-shot. Sampled on start.
REQ-010 SHALL have port ad_data, input, DATA_W bits: ADC sample.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: 1-cycle pulse when a window result is valid.
REQ-013 SHALL have port ms_out, output, 2*DATA_W bits: mean square of the last completed window.
REQ-014 SHALL have port rms_out, output, DATA_W bits: floor(sqrt(ms_out)) of the last completed window.

Function
REQ-015 SHALL pass samp_clk through 2 synchronizer flops plus 1 delay flop; strobe = sync_q & ~delay_q, giving exactly 1 clk_sys pulse per samp_clk rising edge.
REQ-016 SHALL implement states IDLE, ACCUM, LATCH, SQRT, DONE.
REQ-017 IDLE: start=1 and stop=0 clears the accumulator and sample counter, latches mode_cont, and moves to ACCUM.
REQ-018 In ACCUM, a strobe SHALL capture ad_data (cycle t); the square is registered at t+1 and added to the accumulator at t+2; the counter increments at capture.
REQ-019 The accumulator SHALL be 2*DATA_W+LOG2_N bits wide and SHALL never overflow.
REQ-020 Squares SHALL be computed at full width: for unsigned data the maximum is (2^DATA_W-1)^2; for signed data the maximum is 2^(2*DATA_W-2) at the most negative code.
REQ-021 After the N-th capture, strobes SHALL be ignored; the FSM moves to LATCH in the cycle after the N-th product is accumulated.
REQ-022 LATCH: the mean square is acc >> LOG2_N (truncating) and SHALL be held internally; then the FSM moves to SQRT if RMS_SQRT_EN is defined, otherwise to DONE.
REQ-023 SQRT: restoring integer square root, 1 result bit per cycle, exactly DATA_W cycles, then DONE.
REQ-024 DONE: ms_out and rms_out update and done=1 for exactly 1 cycle.
REQ-025 After DONE, the FSM goes to IDLE if single-shot; if continuous, it clears the accumulator and counter and returns to ACCUM.
REQ-026 Strobes arriving in LATCH, SQRT or DONE SHALL be discarded; they do not count toward the next window.
REQ-027 stop=1 in any state SHALL return the FSM to IDLE next cycle; no done pulse; ms_out and rms_out keep their previous values.
REQ-028 start while busy SHALL be ignored; if start and stop are high in the same cycle, stop wins.
REQ-029 ms_out and rms_out SHALL change only in the DONE cycle.

Reset
REQ-030 rst=1 SHALL set the FSM to IDLE and clear busy, done, ms_out, rms_out, the accumulator, the counter, the pipeline registers and the synchronizer flops, all on the next clk_sys edge.
REQ-031 rst asserted mid-window SHALL discard the window; the first strobe after reset is not counted unless a new start is issued.

Configuration
REQ-032 Macro RMS_SQRT_EN defined: the SQRT state and square-root datapath are present, and rms_out is valid per REQ-024.
REQ-033 Macro RMS_SQRT_EN not defined: no square-root logic; LATCH goes directly to DONE; rms_out is tied to 0; ms_out behaviour is unchanged.

Verification (DATA_W=12, LOG2_N=8, RMS_SQRT_EN defined unless stated)
REQ-034 Unsigned, constant ad_data=100, start, single-shot -> exactly 256 strobes counted, ms_out=10000, rms_out=100, one done pulse, busy low afterwards.
REQ-035 Unsigned, ad_data alternating 0/4095 per strobe -> ms_out=8384512, rms_out=2895; repeat with the macro undefined -> ms_out=8384512, rms_out=0, done exactly 12 cycles earlier.
REQ-036 SIGNED=1, constant ad_data=12'h800 -> ms_out=4194304, rms_out=2048; constant 12'h7FF -> ms_out=4190209, rms_out=2047.
REQ-037 mode_cont=1, constant 4095 -> successive done pulses each with ms_out=16769025, rms_out=4095; strobes during SQRT are not counted (window still exactly 256 samples).
REQ-038 stop after 100 strobes -> FSM returns to IDLE, no done pulse, outputs retain previous values; start and stop in the same cycle -> FSM stays IDLE.
REQ-039 rst pulse at strobe 200 -> all outputs 0 next cycle; a new start gives a clean 256-sample result matching REQ-034.
